// File: rtl/ring_osc_entropy_sampler.sv
// -----------------------------------------------------------------------------
// ring_osc_entropy_sampler
//
// Purpose:
//   Samples an external ring-oscillator array, folds all rings into one raw
//   bit per sample strobe, runs a repetition-count health test, optionally
//   von Neumann debiases the raw stream and assembles the result into words
//   delivered over a valid/ready handshake.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   run request; low returns the block to IDLE
//   debias       in   1 = von Neumann debiasing, 0 = raw bits (taken in IDLE)
//   ring_in      in   [NUM_RINGS]  asynchronous ring-oscillator outputs
//   ring_en      out  [NUM_RINGS]  per-ring enable, all bits equal
//   data         out  [WORD_BITS]  assembled random word
//   valid        out  data holds an unconsumed word
//   ready        in   consumer accepts data when valid && ready
//   health_fail  out  sticky repetition-test failure flag
//   overflow     out  sticky flag: a completed word was dropped
//
// Parameter ranges: NUM_RINGS 1..32, WORD_BITS 8..64, SAMPLE_DIV >= 2,
// WARMUP_SAMPLES >= 1, REP_LIMIT >= 2.
// -----------------------------------------------------------------------------
module ring_osc_entropy_sampler #(
    parameter int NUM_RINGS      = 8,
    parameter int WORD_BITS      = 32,
    parameter int SAMPLE_DIV     = 4,
    parameter int WARMUP_SAMPLES = 64,
    parameter int REP_LIMIT      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 debias,
    input  logic [NUM_RINGS-1:0] ring_in,
    output logic [NUM_RINGS-1:0] ring_en,
    output logic [WORD_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 health_fail,
    output logic                 overflow
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WARM_W = $clog2(WARMUP_SAMPLES + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam int CNT_W  = $clog2(WORD_BITS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_SAMPLES - 1);
    localparam logic [REP_W-1:0]  REP_TRIP  = REP_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    // Parity of all synchronised rings: the raw entropy bit.
    function automatic logic xor_reduce(input logic [NUM_RINGS-1:0] v);
        logic p;
        p = 1'b0;
        for (int i = 0; i < NUM_RINGS; i++) begin
            p = p ^ v[i];
        end
        return p;
    endfunction

    state_t                state_q, state_d;
    logic [NUM_RINGS-1:0]  ring_meta_q, ring_sync_q;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
    logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
    logic                  last_bit_q, last_bit_d;
    logic                  debias_q, debias_d;
    logic                  pair_have_q, pair_have_d;
    logic                  pair_bit_q, pair_bit_d;
    logic [WORD_BITS-1:0]  asm_q, asm_d;
    logic [CNT_W-1:0]      asm_cnt_q, asm_cnt_d;
    logic [WORD_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  health_fail_q, health_fail_d;
    logic                  overflow_q, overflow_d;
    logic [NUM_RINGS-1:0]  ring_en_q, ring_en_d;

    logic                  raw_bit_s;
    logic                  strobe_s;
    logic [REP_W-1:0]      rep_next_s;
    logic                  trip_s;
    logic                  emit_s;
    logic                  emit_bit_s;
    logic [WORD_BITS-1:0]  word_s;

    // Two-flop synchroniser for the asynchronous ring outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_meta_q <= {NUM_RINGS{1'b0}};
            ring_sync_q <= {NUM_RINGS{1'b0}};
        end else begin
            ring_meta_q <= ring_in;
            ring_sync_q <= ring_meta_q;
        end
    end

    // Strobe, repetition-count and debias decode for the current cycle.
    always_comb begin
        raw_bit_s  = xor_reduce(ring_sync_q);
        strobe_s   = (div_q == DIV_LAST) &&
                     ((state_q == ST_WARMUP) || (state_q == ST_RUN));
        rep_next_s = REP_W'(1);
        emit_s     = 1'b0;
        emit_bit_s = raw_bit_s;
        // A zero count means no previous bit yet in this run.
        if ((rep_cnt_q != {REP_W{1'b0}}) && (raw_bit_s == last_bit_q)) begin
            rep_next_s = rep_cnt_q + REP_W'(1);
        end else begin
            rep_next_s = REP_W'(1);
        end
        trip_s = strobe_s && (rep_next_s == REP_TRIP);
        // The bit of a tripping strobe is never assembled.
        if ((state_q == ST_RUN) && strobe_s && !trip_s) begin
            if (!debias_q) begin
                emit_s = 1'b1;
            end else if (pair_have_q && (pair_bit_q != raw_bit_s)) begin
                // 01 -> 0, 10 -> 1: the emitted bit is the pair's first bit.
                emit_s     = 1'b1;
                emit_bit_s = pair_bit_q;
            end else begin
                emit_s = 1'b0;
            end
        end else begin
            emit_s = 1'b0;
        end
        // Shift right with the new bit at the MSB, so the first bit of a word
        // ends up at bit 0 once WORD_BITS bits have been shifted in.
        word_s = {emit_bit_s, asm_q[WORD_BITS-1:1]};
    end

    // Next-state logic for the FSM, counters, assembly and output flags.
    always_comb begin
        state_d       = state_q;
        div_d         = (div_q == DIV_LAST) ? {DIV_W{1'b0}} : (div_q + DIV_W'(1));
        warm_cnt_d    = warm_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        last_bit_d    = last_bit_q;
        debias_d      = debias_q;
        pair_have_d   = pair_have_q;
        pair_bit_d    = pair_bit_q;
        asm_d         = asm_q;
        asm_cnt_d     = asm_cnt_q;
        data_d        = data_q;
        valid_d       = valid_q & ~ready;
        health_fail_d = health_fail_q;
        overflow_d    = overflow_q;

        if ((state_q != ST_IDLE) && !enable) begin
            // IDLE entry from any active state, FAIL included.
            state_d       = ST_IDLE;
            valid_d       = 1'b0;
            asm_cnt_d     = {CNT_W{1'b0}};
            health_fail_d = 1'b0;
            pair_have_d   = 1'b0;
            rep_cnt_d     = {REP_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    debias_d = debias;
                    if (enable) begin
                        state_d     = ST_WARMUP;
                        div_d       = {DIV_W{1'b0}};
                        warm_cnt_d  = {WARM_W{1'b0}};
                        rep_cnt_d   = {REP_W{1'b0}};
                        last_bit_d  = 1'b0;
                        pair_have_d = 1'b0;
                        asm_cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WARMUP: begin
                    if (strobe_s) begin
                        rep_cnt_d  = rep_next_s;
                        last_bit_d = raw_bit_s;
                        if (trip_s) begin
                            state_d       = ST_FAIL;
                            health_fail_d = 1'b1;
                            valid_d       = 1'b0;
                            asm_cnt_d     = {CNT_W{1'b0}};
                        end else if (warm_cnt_q == WARM_LAST) begin
                            // Pairing starts fresh in RUN.
                            state_d     = ST_RUN;
                            pair_have_d = 1'b0;
                            asm_cnt_d   = {CNT_W{1'b0}};
                        end else begin
                            warm_cnt_d = warm_cnt_q + WARM_W'(1);
                        end
                    end else begin
                        state_d = ST_WARMUP;
                    end
                end
                ST_RUN: begin
                    if (strobe_s) begin
                        rep_cnt_d  = rep_next_s;
                        last_bit_d = raw_bit_s;
                        if (trip_s) begin
                            state_d       = ST_FAIL;
                            health_fail_d = 1'b1;
                            valid_d       = 1'b0;
                            asm_cnt_d     = {CNT_W{1'b0}};
                        end else begin
                            if (debias_q) begin
                                pair_have_d = ~pair_have_q;
                                pair_bit_d  = pair_have_q ? pair_bit_q : raw_bit_s;
                            end else begin
                                pair_have_d = 1'b0;
                            end
                            if (emit_s) begin
                                asm_d = word_s;
                                if (asm_cnt_q == WORD_LAST) begin
                                    asm_cnt_d = {CNT_W{1'b0}};
                                    if (!valid_q || ready) begin
                                        data_d  = word_s;
                                        valid_d = 1'b1;
                                    end else begin
                                        overflow_d = 1'b1;
                                    end
                                end else begin
                                    asm_cnt_d = asm_cnt_q + CNT_W'(1);
                                end
                            end else begin
                                asm_d = asm_q;
                            end
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    asm_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end

        ring_en_d = (state_d != ST_IDLE) ? {NUM_RINGS{1'b1}} : {NUM_RINGS{1'b0}};
    end

    // State, counter, assembly and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            div_q         <= {DIV_W{1'b0}};
            warm_cnt_q    <= {WARM_W{1'b0}};
            rep_cnt_q     <= {REP_W{1'b0}};
            last_bit_q    <= 1'b0;
            debias_q      <= 1'b0;
            pair_have_q   <= 1'b0;
            pair_bit_q    <= 1'b0;
            asm_q         <= {WORD_BITS{1'b0}};
            asm_cnt_q     <= {CNT_W{1'b0}};
            data_q        <= {WORD_BITS{1'b0}};
            valid_q       <= 1'b0;
            health_fail_q <= 1'b0;
            overflow_q    <= 1'b0;
            ring_en_q     <= {NUM_RINGS{1'b0}};
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            warm_cnt_q    <= warm_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            last_bit_q    <= last_bit_d;
            debias_q      <= debias_d;
            pair_have_q   <= pair_have_d;
            pair_bit_q    <= pair_bit_d;
            asm_q         <= asm_d;
            asm_cnt_q     <= asm_cnt_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            health_fail_q <= health_fail_d;
            overflow_q    <= overflow_d;
            ring_en_q     <= ring_en_d;
        end
    end

    assign ring_en     = ring_en_q;
    assign data        = data_q;
    assign valid       = valid_q;
    assign health_fail = health_fail_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/ring_osc_entropy_sampler.md
RING_OSC_ENTROPY_SAMPLER -- requirements
Module: ring_osc_entropy_sampler

Interface
REQ-001 Parameter NUM_RINGS, default 8, number of ring-oscillator channels sampled (1..32).
REQ-002 Parameter WORD_BITS, default 32, output word width (8..64).
REQ-003 Parameter SAMPLE_DIV, default 4, clk cycles between sample strobes (>=2).
REQ-004 Parameter WARMUP_SAMPLES, default 64, raw samples discarded after enable before output starts.
REQ-005 Parameter REP_LIMIT, default 16, consecutive identical raw bits that trip the health test (>=2).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 enable  input  1  run request; low returns the block to IDLE.
REQ-009 debias  input  1  1 = von Neumann debiasing on, 0 = raw bits used directly; sampled only in IDLE.
REQ-010 ring_in  input  NUM_RINGS  asynchronous outputs of the external ring-oscillator array.
REQ-011 ring_en  output  NUM_RINGS  per-ring enable, all bits equal.
REQ-012 data  output  WORD_BITS  assembled random word.
REQ-013 valid  output  1  data holds an unconsumed word.
REQ-014 ready  input  1  consumer accepts data when valid && ready.
REQ-015 health_fail  output  1  sticky health-test failure flag.
REQ-016 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-017 ring_in SHALL pass through a 2-flop synchroniser per bit before any other use.
REQ-018 A sample strobe SHALL fire every SAMPLE_DIV cycles from a free-running divider that is cleared on entry to WARMUP.
REQ-019 Raw bit SHALL be the XOR of all synchronised ring bits at the strobe.
REQ-020 States: IDLE, WARMUP, RUN, FAIL; IDLE->WARMUP when enable=1; WARMUP->RUN after WARMUP_SAMPLES strobes; RUN->FAIL on health trip; any state->IDLE when enable=0, including FAIL.
REQ-021 ring_en SHALL be all-ones in WARMUP, RUN and FAIL, all-zeros in IDLE.
REQ-022 Health test: counter of consecutive equal raw bits, active in WARMUP and RUN; reaching REP_LIMIT SHALL set health_fail and enter FAIL on the next cycle.
REQ-023 health_fail SHALL stay set until reset or IDLE entry.
REQ-024 In RUN with debias=0, each raw bit SHALL shift into the assembly register, LSB first (first bit ends at bit 0).
REQ-025 In RUN with debias=1, raw bits SHALL be paired in strobe order: 01 -> emit 0, 10 -> emit 1, 00 and 11 -> emit nothing; a pair never spans WARMUP/RUN.
REQ-026 When WORD_BITS bits are assembled: if valid=0, or valid=1 and ready=1 in the same cycle, load data and set valid next cycle; else drop the word and set overflow. The assembly count SHALL restart at 0 either way.
REQ-027 valid SHALL fall the cycle after valid && ready unless a new word loads that same cycle; data SHALL be stable while valid=1 and ready=0.
REQ-028 Entering FAIL or IDLE SHALL clear valid and the assembly count; data keeps its last value.
REQ-029 The latency from the strobe carrying the last bit to valid high SHALL be 1 clk.

Reset
REQ-030 On rst_n low: state IDLE; synchronisers, divider, counters and assembly register 0; data 0; valid, health_fail, overflow, ring_en 0.
REQ-031 Reset assertion mid-word SHALL discard the partial word; no valid pulse follows reset release until a full WARMUP and word complete.

Verification
REQ-032 Debias=0, WORD_BITS=8, WARMUP_SAMPLES=2, ring_in XOR driven 1,0,1,1,0,0,1,0 after warmup, ready=1 -> data=8'h4D, valid one cycle.
REQ-033 Debias=1, raw pairs 01,11,10,00,10 -> emitted bits 0,1,1 in bits 0..2; no word until WORD_BITS emitted bits.
REQ-034 ring_in held constant for REP_LIMIT=16 strobes -> health_fail=1, state FAIL, valid=0; enable toggled low then high -> health_fail=0, WARMUP restarts.
REQ-035 ready=0 with valid=1 while a second word completes -> overflow=1, data unchanged; ready=1 with a word completing in the same cycle -> new word loads, valid stays 1, overflow unchanged.
REQ-036 rst_n pulsed low mid-word in RUN -> all outputs 0 asynchronously; after release, no valid before WARMUP_SAMPLES + WORD_BITS strobes.
REQ-037 enable=0 -> ring_en=0 within 1 clk and valid=0.
